// File: rtl/flip_input_ctrl.sv
// Flipper button front-end: per-side synchronizer, debounce FSM and hold-time limiter
// producing level move commands and one-cycle press strobes.
module flip_input_ctrl #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned MAX_HOLD_CYCLES = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic btn_left_n,
   input  logic btn_right_n,
   output logic move_left_flip,
   output logic move_right_flip,
   output logic press_left_pulse,
   output logic press_right_pulse
);

   localparam logic [31:0] DbLast   = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] HoldLast = 32'(MAX_HOLD_CYCLES - 1);
   localparam bit          HoldEn   = (MAX_HOLD_CYCLES != 0);

   // Bit 2 set exactly in the states that raise the flipper, so move is a plain flop output.
   typedef enum logic [2:0] {
      StIdle      = 3'b000,
      StArming    = 3'b001,
      StLockout   = 3'b010,
      StHeld      = 3'b100,
      StDisarming = 3'b101
   } state_e;

   logic [1:0]             w_btn_n;
   logic [1:0]             w_pressed;
   logic [SYNC_STAGES-1:0] r_sync [2];

   state_e      r_state [2];
   state_e      w_state_d [2];
   logic [31:0] r_db_cnt [2];
   logic [31:0] w_db_cnt_d [2];
   logic [31:0] r_hold_cnt [2];
   logic [31:0] w_hold_cnt_d [2];
   logic [1:0]  r_pulse;
   logic [1:0]  w_pulse_d;

   assign w_btn_n = {btn_right_n, btn_left_n};

   // Synchronizers keep running while disabled; reset loads the released (high) level.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (rst) begin
            r_sync[s] <= '1;
         end else begin
            r_sync[s] <= {r_sync[s][SYNC_STAGES-2:0], w_btn_n[s]};
         end
      end
   end

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_pressed[s] = ~r_sync[s][SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (rst) begin
            r_state[s]    <= StIdle;
            r_db_cnt[s]   <= '0;
            r_hold_cnt[s] <= '0;
            r_pulse[s]    <= 1'b0;
         end else begin
            r_state[s]    <= w_state_d[s];
            r_db_cnt[s]   <= w_db_cnt_d[s];
            r_hold_cnt[s] <= w_hold_cnt_d[s];
            r_pulse[s]    <= w_pulse_d[s];
         end
      end
   end

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_state_d[s]    = r_state[s];
         w_db_cnt_d[s]   = r_db_cnt[s];
         w_hold_cnt_d[s] = r_hold_cnt[s];
         w_pulse_d[s]    = 1'b0;
         if (!enable) begin
            w_state_d[s]    = StIdle;
            w_db_cnt_d[s]   = '0;
            w_hold_cnt_d[s] = '0;
         end else begin
            unique case (r_state[s])
               StIdle: begin
                  if (w_pressed[s]) begin
                     w_state_d[s]  = StArming;
                     w_db_cnt_d[s] = '0;
                  end
               end
               StArming: begin
                  if (!w_pressed[s]) begin
                     w_state_d[s] = StIdle;
                  end else if (r_db_cnt[s] == DbLast) begin
                     w_state_d[s]    = StHeld;
                     w_hold_cnt_d[s] = '0;
                     w_pulse_d[s]    = 1'b1;
                  end else begin
                     w_db_cnt_d[s] = r_db_cnt[s] + 32'd1;
                  end
               end
               StHeld: begin
                  w_hold_cnt_d[s] = r_hold_cnt[s] + 32'd1;
                  if (HoldEn && r_hold_cnt[s] == HoldLast) begin
                     w_state_d[s]  = StLockout;
                     w_db_cnt_d[s] = '0;
                  end else if (!w_pressed[s]) begin
                     w_state_d[s]  = StDisarming;
                     w_db_cnt_d[s] = '0;
                  end
               end
               StDisarming: begin
                  w_hold_cnt_d[s] = r_hold_cnt[s] + 32'd1;
                  if (w_pressed[s]) begin
                     w_state_d[s] = StHeld;
                  end else if (r_db_cnt[s] == DbLast) begin
                     w_state_d[s] = StIdle;
                  end else if (HoldEn && r_hold_cnt[s] == HoldLast) begin
                     w_state_d[s]  = StLockout;
                     w_db_cnt_d[s] = '0;
                  end else begin
                     w_db_cnt_d[s] = r_db_cnt[s] + 32'd1;
                  end
               end
               StLockout: begin
                  if (w_pressed[s]) begin
                     w_db_cnt_d[s] = '0;
                  end else if (r_db_cnt[s] == DbLast) begin
                     w_state_d[s] = StIdle;
                  end else begin
                     w_db_cnt_d[s] = r_db_cnt[s] + 32'd1;
                  end
               end
               default: begin
                  w_state_d[s]    = StIdle;
                  w_db_cnt_d[s]   = '0;
                  w_hold_cnt_d[s] = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      move_left_flip    = r_state[0][2];
      move_right_flip   = r_state[1][2];
      press_left_pulse  = r_pulse[0];
      press_right_pulse = r_pulse[1];
   end

endmodule

// File: tb/tb_flip_input_ctrl.sv
// Scoreboard bench for flip_input_ctrl: run-length reference model feeds an expectation
// queue that a posedge monitor drains; a few spec-derived totals are checked directly.
module tb_flip_input_ctrl;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DB   = 4;
   localparam int unsigned MAXH = 20;

   logic clk = 1'b0;
   logic rst, enable, btn_left_n, btn_right_n;
   logic move_left_flip, move_right_flip, press_left_pulse, press_right_pulse;

   always #5 clk = ~clk;

   flip_input_ctrl #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DB),
      .MAX_HOLD_CYCLES(MAXH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .btn_left_n       (btn_left_n),
      .btn_right_n      (btn_right_n),
      .move_left_flip   (move_left_flip),
      .move_right_flip  (move_right_flip),
      .press_left_pulse (press_left_pulse),
      .press_right_pulse(press_right_pulse)
   );

   typedef struct packed {
      logic ml;
      logic mr;
      logic pl;
      logic pr;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;

   // Model: mode 0 = down, 1 = up, 2 = locked out. run = consecutive qualifying samples,
   // hi = cycles the flipper has been up in this press.
   int m_mode [2];
   int m_run  [2];
   int m_hi   [2];
   bit m_pulse[2];
   bit m_sync [2][SYNC];

   int obs_pulse[2];
   int obs_high [2];

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%b required=%b", name, cycle, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_side(input int s, input bit p, input bit en);
      m_pulse[s] = 1'b0;
      if (!en) begin
         m_mode[s] = 0;
         m_run[s]  = 0;
         m_hi[s]   = 0;
         return;
      end
      case (m_mode[s])
         0: begin
            // Up after DB+1 consecutive pressed samples.
            m_run[s] = p ? m_run[s] + 1 : 0;
            if (m_run[s] == int'(DB) + 1) begin
               m_mode[s]  = 1;
               m_run[s]   = 0;
               m_hi[s]    = 1;
               m_pulse[s] = 1'b1;
            end
         end
         1: begin
            if (m_run[s] > 0) begin
               if (p) begin
                  m_run[s] = 0;
                  m_hi[s]++;
               end else begin
                  m_run[s]++;
                  if (m_run[s] == int'(DB) + 1) begin
                     m_mode[s] = 0;
                     m_run[s]  = 0;
                  end else if (MAXH != 0 && m_hi[s] == int'(MAXH)) begin
                     m_mode[s] = 2;
                     m_run[s]  = 0;
                  end else begin
                     m_hi[s]++;
                  end
               end
            end else if (MAXH != 0 && m_hi[s] == int'(MAXH)) begin
               m_mode[s] = 2;
               m_run[s]  = 0;
            end else begin
               if (!p) m_run[s] = 1;
               m_hi[s]++;
            end
         end
         default: begin
            // Locked out until DB consecutive released samples.
            m_run[s] = p ? 0 : m_run[s] + 1;
            if (m_run[s] == int'(DB)) begin
               m_mode[s] = 0;
               m_run[s]  = 0;
            end
         end
      endcase
   endtask

   task automatic step(input bit r, input bit en, input bit bl, input bit br);
      bit   raw[2];
      bit   p[2];
      exp_t e;
      @(negedge clk);
      rst         = r;
      enable      = en;
      btn_left_n  = bl;
      btn_right_n = br;
      raw[0] = bl;
      raw[1] = br;
      for (int s = 0; s < 2; s++) p[s] = !m_sync[s][SYNC-1];
      for (int s = 0; s < 2; s++) begin
         if (r) begin
            m_mode[s]  = 0;
            m_run[s]   = 0;
            m_hi[s]    = 0;
            m_pulse[s] = 1'b0;
            for (int k = 0; k < int'(SYNC); k++) m_sync[s][k] = 1'b1;
         end else begin
            model_side(s, p[s], en);
            for (int k = int'(SYNC) - 1; k > 0; k--) m_sync[s][k] = m_sync[s][k-1];
            m_sync[s][0] = raw[s];
         end
      end
      e.ml = (m_mode[0] == 1);
      e.mr = (m_mode[1] == 1);
      e.pl = m_pulse[0];
      e.pr = m_pulse[1];
      exp_q.push_back(e);
   endtask

   task automatic clear_obs();
      for (int s = 0; s < 2; s++) begin
         obs_pulse[s] = 0;
         obs_high[s]  = 0;
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("move_left_flip", move_left_flip, e.ml);
         check("move_right_flip", move_right_flip, e.mr);
         check("press_left_pulse", press_left_pulse, e.pl);
         check("press_right_pulse", press_right_pulse, e.pr);
         if (press_left_pulse === 1'b1) obs_pulse[0]++;
         if (press_right_pulse === 1'b1) obs_pulse[1]++;
         if (move_left_flip === 1'b1) obs_high[0]++;
         if (move_right_flip === 1'b1) obs_high[1]++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cycle=%0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      int  rem[2];
      bit  lvl[2];
      int  wait_cnt;
      rst         = 1'b1;
      enable      = 1'b1;
      btn_left_n  = 1'b1;
      btn_right_n = 1'b1;
      clear_obs();

      for (int i = 0; i < 3; i++) step(1, 1, 1, 1);

      // Clean left press, 10 cycles.
      clear_obs();
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
      check_int("s1_left_pulses", obs_pulse[0], 1);
      check_int("s1_left_high_cycles", obs_high[0], 10);
      check_int("s1_right_high_cycles", obs_high[1], 0);

      // Bouncy left press, then stable.
      clear_obs();
      for (int i = 0; i < 15; i++) step(0, 1, ((i / 3) % 2) == 1, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
      check_int("s2_left_pulses", obs_pulse[0], 1);

      // Right held past the hold limit, released, pressed again.
      clear_obs();
      for (int i = 0; i < 40; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1);
      check_int("s3_right_high_limited", obs_high[1], int'(MAXH));
      check_int("s3_right_pulses_first", obs_pulse[1], 1);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
      check_int("s3_right_pulses_total", obs_pulse[1], 2);

      // Simultaneous presses.
      clear_obs();
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
      check_int("s4_left_pulses", obs_pulse[0], 1);
      check_int("s4_right_pulses", obs_pulse[1], 1);

      // Enable dropped for one cycle during a held press.
      clear_obs();
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);
      check_int("s5_left_pulses", obs_pulse[0], 2);

      // Reset while held with the pulse high, button still held afterwards.
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);

      // Randomized run-length stimulus with occasional enable drops and resets.
      for (int s = 0; s < 2; s++) begin
         rem[s] = 0;
         lvl[s] = 1'b1;
      end
      for (int i = 0; i < 3000; i++) begin
         for (int s = 0; s < 2; s++) begin
            if (rem[s] == 0) begin
               lvl[s] = ~lvl[s];
               rem[s] = int'($urandom_range(1, 30));
            end
            rem[s]--;
         end
         step($urandom_range(0, 499) == 0, $urandom_range(0, 59) != 0, lvl[0], lvl[1]);
      end
      for (int i = 0; i < 40; i++) step(0, 1, 1, 1);

      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flip_input_ctrl.md
# flip_input_ctrl

Button front-end for the flipper subsystem: turns the two raw, bouncy, active-low board pushbuttons into the clean, level-type `move_left_flip` / `move_right_flip` commands consumed by the flipper animation block. Each side has a synchronizer, a debounce FSM, and a hold-time limiter that auto-drops a flipper held too long. Single-cycle press pulses are also produced for the score and sound logic. It sits between the board KEY pins and the flipper animation block.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per button (≥2).
- `DEBOUNCE_CYCLES`, 1000000: cycles the synced level must stay stable to be accepted (20 ms at 50 MHz, ≥1).
- `MAX_HOLD_CYCLES`, 100000000: maximum cycles `move_*` may stay high per press (2 s). A value of 0 disables the limit.
- `clk` in 1: 50 MHz base clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `enable` in 1: when 0, both sides are forced idle.
- `btn_left_n` in 1: raw left pushbutton, active-low, asynchronous.
- `btn_right_n` in 1: raw right pushbutton, active-low, asynchronous.
- `move_left_flip` out 1: left flipper raise command, level.
- `move_right_flip` out 1: right flipper raise command, level.
- `press_left_pulse` out 1: one-cycle strobe on each accepted left press.
- `press_right_pulse` out 1: one-cycle strobe on each accepted right press.

## Operation
- Each side is independent and identical. The descriptions below use `p` = synced, inverted button level (1 = pressed).
- **Synchronizer:** `SYNC_STAGES` flops clocked on `clk`. `p` is taken from the last stage.
- **Counters:** 32-bit `db_cnt` (debounce) and 32-bit `hold_cnt` per side. Neither wraps within the ranges used.
- **IDLE** (move=0):
  - `p`=1 → ARMING, `db_cnt`←0.
- **ARMING** (move=0):
  - `p`=0 → IDLE.
  - Else if `db_cnt`==DEBOUNCE_CYCLES−1 → HELD, `hold_cnt`←0, press pulse=1 for the next cycle.
  - Else `db_cnt`++.
- **HELD** (move=1), `hold_cnt`++ each cycle:
  - If MAX_HOLD_CYCLES≠0 and `hold_cnt`==MAX_HOLD_CYCLES−1 → LOCKOUT. This check has priority over release.
  - Else if `p`=0 → DISARMING, `db_cnt`←0.
- **DISARMING** (move=1), `hold_cnt` keeps counting:
  - `p`=1 → HELD, `hold_cnt` not cleared.
  - Else if `db_cnt`==DEBOUNCE_CYCLES−1 → IDLE. This has priority over the hold limit on the same edge.
  - Else if the hold limit is hit → LOCKOUT.
  - Else `db_cnt`++.
- **LOCKOUT** (move=0): the button must be released before it can fire again.
  - `p`=1 → `db_cnt`←0.
  - Else if `db_cnt`==DEBOUNCE_CYCLES−1 → IDLE.
  - Else `db_cnt`++.
- `move_*` is decoded from a registered state (HELD or DISARMING) and is glitch-free.
- Press pulses are registered and last exactly one cycle. A re-entry into HELD from DISARMING produces no pulse.
- `enable`=0, sampled at an edge:
  - Both FSMs go to IDLE and all counters clear.
  - Outputs are 0 from the next cycle.
  - Synchronizers keep running.
  - When `enable` returns to 1 while a button is still held, a fresh ARMING sequence starts (new debounce, new pulse).
- `rst` has priority over `enable`. It forces the FSMs to IDLE, counters to 0, and synchronizer flops to the released level.

## Timing
- Reset values: `move_left_flip`=0, `move_right_flip`=0, `press_left_pulse`=0, `press_right_pulse`=0.
- **Press latency:** the button is held stable from the edge that first samples it pressed (edge 0). `move_*` and the pulse go high after edge SYNC_STAGES+DEBOUNCE_CYCLES. The pulse falls one edge later.
- **Release latency:** `move_*` falls after edge SYNC_STAGES+DEBOUNCE_CYCLES, counted from the first edge sampling released.
- **Bounces:** any bounce shorter than DEBOUNCE_CYCLES restarts the debounce. No output toggles.
- **Hold limit:** with a continuous press, `move_*` is high for exactly MAX_HOLD_CYCLES cycles, then 0 until the button has been released ≥DEBOUNCE_CYCLES (plus sync delay).
- **Simultaneous presses:** left and right never interact. Simultaneous presses give simultaneous outputs.
- **Reset mid-press:** all outputs are 0 after the `rst` edge. A button still held after reset deasserts is treated as a new press.

## Test plan
Bench parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MAX_HOLD_CYCLES=20.

1. Clean left press of 10 cycles → `move_left_flip` rises after edge 6, `press_left_pulse` is high one cycle, `move_left_flip` falls 6 edges after release, right outputs stay 0.
2. Left press with 3-cycle high glitches every 3 cycles for 15 cycles, then stable → no output until 4 stable synced cycles, exactly one pulse.
3. Right press held 40 cycles → `move_right_flip` high exactly 20 cycles, then 0 with no re-fire while held; release ≥6 cycles, re-press → new pulse, move high again.
4. Both pressed on the same edge → both moves and both pulses rise on the same cycle.
5. Held press with `enable` dropped for 1 cycle → moves are 0 the next cycle; with `enable` back and the button still held, move re-rises 4 edges later with a new pulse.
6. `rst` asserted while a side is HELD and a pulse is pending → all outputs 0 after the edge. After release of `rst` with the button held, move rises SYNC_STAGES+DEBOUNCE_CYCLES edges later.
